// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the multi-cycle MIPS controller
package mips_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_LUI  = 3'b011;

  // Instruction classes as seen by the FSM; ALU covers addu/subu/ori/lui.
  localparam logic [2:0] CL_ILL   = 3'd0;
  localparam logic [2:0] CL_J     = 3'd1;
  localparam logic [2:0] CL_BEQ   = 3'd2;
  localparam logic [2:0] CL_LW    = 3'd3;
  localparam logic [2:0] CL_SW    = 3'd4;
  localparam logic [2:0] CL_ALU   = 3'd5;

endpackage

// File: rtl/mips_decode.sv
// rtl/mips_decode.sv - combinational instruction decoder: class and datapath selects
module mips_decode
  import mips_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] cls_o,
  output logic       reg_dst_o,
  output logic       alu_src_o,
  output logic       mem_to_reg_o,
  output logic       ext_op_o,
  output logic [2:0] alu_op_o
);

  // Decode opcode (and funct for R-type); anything unrecognised is illegal with zero selects.
  always_comb begin
    cls_o        = CL_ILL;
    reg_dst_o    = 1'b0;
    alu_src_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    ext_op_o     = 1'b0;
    alu_op_o     = ALU_ADD;
    case (op_i)
      OP_RTYPE: begin
        if (funct_i == FN_ADDU) begin
          cls_o     = CL_ALU;
          reg_dst_o = 1'b1;
          alu_op_o  = ALU_ADD;
        end else if (funct_i == FN_SUBU) begin
          cls_o     = CL_ALU;
          reg_dst_o = 1'b1;
          alu_op_o  = ALU_SUB;
        end
      end
      OP_ORI: begin
        cls_o     = CL_ALU;
        alu_src_o = 1'b1;
        alu_op_o  = ALU_OR;
      end
      OP_LUI: begin
        cls_o     = CL_ALU;
        alu_src_o = 1'b1;
        alu_op_o  = ALU_LUI;
      end
      OP_LW: begin
        cls_o        = CL_LW;
        alu_src_o    = 1'b1;
        mem_to_reg_o = 1'b1;
        ext_op_o     = 1'b1;
        alu_op_o     = ALU_ADD;
      end
      OP_SW: begin
        cls_o     = CL_SW;
        alu_src_o = 1'b1;
        ext_op_o  = 1'b1;
        alu_op_o  = ALU_ADD;
      end
      OP_BEQ: begin
        cls_o    = CL_BEQ;
        ext_op_o = 1'b1;
        alu_op_o = ALU_SUB;
      end
      OP_J: begin
        cls_o = CL_J;
      end
      default: begin
        cls_o = CL_ILL;
      end
    endcase
  end

endmodule

// File: rtl/mips_ctrl.sv
// rtl/mips_ctrl.sv - multi-cycle MIPS control FSM with IR, strobes and retired-instruction counter
module mips_ctrl
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ins,
  output logic        pc_wr,
  output logic        npc_sel,
  output logic        jctl,
  output logic        reg_wr,
  output logic        mem_wr,
  output logic        reg_dst,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic        ext_op,
  output logic [2:0]  alu_op,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] instr_cnt
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;

  logic [2:0]  cls;
  logic        dec_reg_dst, dec_alu_src, dec_mem_to_reg, dec_ext_op;
  logic [2:0]  dec_alu_op;
  logic        sel_en;

  // Only opcode and funct drive decoding; the operand fields are carried for the datapath.
  logic unused_ir;
  assign unused_ir = ^ir_q[25:6];

  mips_decode u_decode (
    .op_i         (ir_q[31:26]),
    .funct_i      (ir_q[5:0]),
    .cls_o        (cls),
    .reg_dst_o    (dec_reg_dst),
    .alu_src_o    (dec_alu_src),
    .mem_to_reg_o (dec_mem_to_reg),
    .ext_op_o     (dec_ext_op),
    .alu_op_o     (dec_alu_op)
  );

  // State, IR and counter registers; reset forces IF immediately so all strobes drop at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IF;
      ir_q        <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  // IR captures ins only on the IF->ID edge; the counter advances on each retiring cycle.
  always_comb begin
    ir_d        = (state_q == S_IF) ? ins : ir_q;
    instr_cnt_d = instr_cnt_q + {31'd0, pc_wr};
  end

  // Next-state and strobe generation; pc_wr marks the final cycle of every instruction.
  always_comb begin
    state_d = S_IF;
    pc_wr   = 1'b0;
    npc_sel = 1'b0;
    jctl    = 1'b0;
    reg_wr  = 1'b0;
    mem_wr  = 1'b0;
    illegal = 1'b0;
    sel_en  = 1'b0;
    case (state_q)
      S_IF: begin
        state_d = S_ID;
      end
      S_ID: begin
        sel_en = 1'b1;
        if (cls == CL_J) begin
          pc_wr = 1'b1;
          jctl  = 1'b1;
        end else if (cls == CL_ILL) begin
          pc_wr   = 1'b1;
          illegal = 1'b1;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        sel_en = 1'b1;
        if (cls == CL_BEQ) begin
          pc_wr   = 1'b1;
          npc_sel = 1'b1;
        end else if (cls == CL_LW || cls == CL_SW) begin
          state_d = S_MEM;
        end else if (cls == CL_ALU) begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        sel_en = 1'b1;
        if (cls == CL_SW) begin
          mem_wr = 1'b1;
          pc_wr  = 1'b1;
        end else if (cls == CL_LW) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        sel_en = 1'b1;
        reg_wr = 1'b1;
        pc_wr  = 1'b1;
      end
      default: begin
        state_d = S_IF;
      end
    endcase
  end

  // Selects follow the IR from ID onward and are forced low in IF and unused encodings.
  always_comb begin
    reg_dst    = sel_en & dec_reg_dst;
    alu_src    = sel_en & dec_alu_src;
    mem_to_reg = sel_en & dec_mem_to_reg;
    ext_op     = sel_en & dec_ext_op;
    alu_op     = sel_en ? dec_alu_op : 3'b000;
  end

  assign state     = state_q;
  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_mips_ctrl.sv
// tb/tb_mips_ctrl.sv - table-driven self-checking bench for mips_ctrl
module tb_mips_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ins;
  logic        pc_wr, npc_sel, jctl, reg_wr, mem_wr;
  logic        reg_dst, alu_src, mem_to_reg, ext_op, illegal;
  logic [2:0]  alu_op;
  logic [2:0]  state;
  logic [31:0] instr_cnt;

  always #5 clk = ~clk;

  mips_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .ins        (ins),
    .pc_wr      (pc_wr),
    .npc_sel    (npc_sel),
    .jctl       (jctl),
    .reg_wr     (reg_wr),
    .mem_wr     (mem_wr),
    .reg_dst    (reg_dst),
    .alu_src    (alu_src),
    .mem_to_reg (mem_to_reg),
    .ext_op     (ext_op),
    .alu_op     (alu_op),
    .illegal    (illegal),
    .state      (state),
    .instr_cnt  (instr_cnt)
  );

  typedef struct {
    string       name;
    logic [31:0] ins;
    int          len;
    logic [14:0] seq;
    logic [4:0]  stb;
    logic [6:0]  sel;
  } vec_t;

  vec_t        vecs[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_cnt  = 32'd0;
  logic [4:0]  stb_now;
  logic [6:0]  sel_now;

  assign stb_now = {reg_wr, mem_wr, npc_sel, jctl, illegal};
  assign sel_now = {reg_dst, alu_src, mem_to_reg, ext_op, alu_op};

  function automatic vec_t mk(input string nm, input logic [31:0] i, input int l,
                              input logic [14:0] s, input logic [4:0] st, input logic [6:0] se);
    vec_t v;
    v.name = nm; v.ins = i; v.len = l; v.seq = s; v.stb = st; v.sel = se;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_quiet(input string nm);
    chk({nm, " state"}, {29'd0, state}, 32'd0);
    chk({nm, " pc_wr"}, {31'd0, pc_wr}, 32'd0);
    chk({nm, " strobes"}, {27'd0, stb_now}, 32'd0);
    chk({nm, " selects"}, {25'd0, sel_now}, 32'd0);
  endtask

  // Entered at a falling edge with the DUT in IF; leaves at the falling edge of the next IF.
  task automatic run_vec(input vec_t v);
    logic [2:0] es;
    ins = v.ins;
    for (int k = 0; k < v.len; k++) begin
      if (k > 0) @(negedge clk);
      es = v.seq[3*k +: 3];
      chk({v.name, " state"}, {29'd0, state}, {29'd0, es});
      chk({v.name, " pc_wr"}, {31'd0, pc_wr}, (k == v.len - 1) ? 32'd1 : 32'd0);
      chk({v.name, " strobes"}, {27'd0, stb_now}, (k == v.len - 1) ? {27'd0, v.stb} : 32'd0);
      chk({v.name, " selects"}, {25'd0, sel_now}, (k == 0) ? 32'd0 : {25'd0, v.sel});
      chk({v.name, " wr_excl"}, {31'd0, reg_wr & mem_wr}, 32'd0);
      if (k == 1) ins = ~v.ins;
    end
    @(negedge clk);
    exp_cnt = exp_cnt + 32'd1;
    chk({v.name, " instr_cnt"}, instr_cnt, exp_cnt);
    chk({v.name, " back_to_if"}, {29'd0, state}, 32'd0);
  endtask

  initial begin
    // strobes {reg_wr,mem_wr,npc_sel,jctl,illegal}; selects {reg_dst,alu_src,mem_to_reg,ext_op,alu_op}
    vecs.push_back(mk("addu", 32'h0022_1821, 4, {3'd0, 3'd4, 3'd2, 3'd1, 3'd0}, 5'b10000, 7'b1000_000));
    vecs.push_back(mk("subu", 32'h0022_1823, 4, {3'd0, 3'd4, 3'd2, 3'd1, 3'd0}, 5'b10000, 7'b1000_001));
    vecs.push_back(mk("ori",  32'h3422_0005, 4, {3'd0, 3'd4, 3'd2, 3'd1, 3'd0}, 5'b10000, 7'b0100_010));
    vecs.push_back(mk("lui",  32'h3C01_0005, 4, {3'd0, 3'd4, 3'd2, 3'd1, 3'd0}, 5'b10000, 7'b0100_011));
    vecs.push_back(mk("lw",   32'h8C04_0004, 5, {3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 5'b10000, 7'b0111_000));
    vecs.push_back(mk("sw",   32'hAC04_0008, 4, {3'd0, 3'd3, 3'd2, 3'd1, 3'd0}, 5'b01000, 7'b0101_000));
    vecs.push_back(mk("beq",  32'h1021_0002, 3, {3'd0, 3'd0, 3'd2, 3'd1, 3'd0}, 5'b00100, 7'b0001_001));
    vecs.push_back(mk("j",    32'h0800_0003, 2, {3'd0, 3'd0, 3'd0, 3'd1, 3'd0}, 5'b00010, 7'b0000_000));
    vecs.push_back(mk("ill_op", 32'hFC00_0000, 2, {3'd0, 3'd0, 3'd0, 3'd1, 3'd0}, 5'b00001, 7'b0000_000));
    vecs.push_back(mk("ill_fn", 32'h0022_182A, 2, {3'd0, 3'd0, 3'd0, 3'd1, 3'd0}, 5'b00001, 7'b0000_000));
    vecs.push_back(mk("ill_zero", 32'h0000_0000, 2, {3'd0, 3'd0, 3'd0, 3'd1, 3'd0}, 5'b00001, 7'b0000_000));

    reset = 1'b0;
    ins   = 32'h0022_1821;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    chk("reset instr_cnt", instr_cnt, 32'd0);
    reset = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while a lw sits in MEM: everything must drop immediately, no retirement.
    ins = 32'h8C04_0004;
    repeat (3) @(negedge clk);
    chk("lw_mid state_mem", {29'd0, state}, 32'd3);
    reset = 1'b0;
    #1;
    check_quiet("mid_reset");
    chk("mid_reset instr_cnt", instr_cnt, 32'd0);
    exp_cnt = 32'd0;
    @(negedge clk);
    check_quiet("held_reset");
    reset = 1'b1;
    run_vec(vecs[0]);

    // Counter wrap: preload all-ones while idle in IF, then retire one jump.
    dut.instr_cnt_q = 32'hFFFF_FFFF;
    exp_cnt = 32'hFFFF_FFFF;
    #1;
    chk("preload instr_cnt", instr_cnt, exp_cnt);
    run_vec(vecs[7]);
    chk("wrap instr_cnt", instr_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_ctrl.md
MIPS_CTRL -- requirements
Module: mips_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low; low forces the reset state immediately.
REQ-003 SHALL have ports: ins  in  32  instruction word from the fetch unit (insout).
REQ-004 SHALL have ports: pc_wr  out  1  PC update strobe to the fetch unit, one cycle per instruction.
REQ-005 SHALL have ports: npc_sel  out  1  branch select to the fetch unit; the fetch unit gates it with ALU zero.
REQ-006 SHALL have ports: jctl  out  1  jump select to the fetch unit.
REQ-007 SHALL have ports: reg_wr, mem_wr  out  1 each  register-file and data-memory write strobes.
REQ-008 SHALL have ports: reg_dst, alu_src, mem_to_reg, ext_op  out  1 each  datapath selects (1 = rd, imm, memory, sign-extend).
REQ-009 SHALL have ports: alu_op  out  3  000 add, 001 sub, 010 or, 011 lui (imm<<16).
REQ-010 SHALL have ports: illegal  out  1  one-cycle pulse on an undecodable instruction.
REQ-011 SHALL have ports: state  out  3  current FSM state; instr_cnt  out  32  retired-instruction count.

Function
REQ-012 SHALL implement a multi-cycle FSM with states IF=0, ID=1, EXE=2, MEM=3, WB=4; other encodings SHALL go to IF.
REQ-013 IF SHALL always go to ID and latch ins into the internal IR on that edge.
REQ-014 ID SHALL decode the IR. j: pc_wr=1, jctl=1, then IF. Illegal: pc_wr=1 (sequential PC), illegal=1, then IF. Otherwise: EXE.
REQ-015 EXE SHALL act by class. beq: pc_wr=1, npc_sel=1, then IF. lw/sw: MEM. addu/subu/ori/lui: WB.
REQ-016 MEM SHALL act by class. sw: mem_wr=1, pc_wr=1, then IF. lw: WB.
REQ-017 WB SHALL assert reg_wr=1 and pc_wr=1, then go to IF.
REQ-018 Instruction latency SHALL be: j/illegal 2 cycles, beq 3, sw/addu/subu/ori/lui 4, lw 5.
REQ-019 Decoding SHALL use opcode [31:26] and, for opcode 000000, funct [5:0].
  - addu: 000000/100001
  - subu: 000000/100011
  - ori: 001101
  - lw: 100011
  - sw: 101011
  - beq: 000100
  - lui: 001111
  - j: 000010
  - All other words are illegal.
REQ-020 Selects SHALL be decoded from the IR only.
  - reg_dst=1 for R-type.
  - alu_src=1 for ori/lw/sw/lui.
  - mem_to_reg=1 for lw.
  - ext_op=1 for lw/sw/beq.
  - alu_op: add for lw/sw, sub for subu/beq, or for ori, lui for lui.
REQ-021 Selects SHALL be held stable from ID through the instruction's last cycle, and SHALL be 0 in IF.
REQ-022 Strobes (pc_wr, reg_wr, mem_wr, npc_sel, jctl, illegal) SHALL be combinational from state and IR, asserted only in the cycles listed above and otherwise 0.
REQ-023 At most one of reg_wr and mem_wr SHALL be high in any cycle, and pc_wr SHALL be high in exactly the last cycle of every instruction.
REQ-024 instr_cnt SHALL increment by 1 on each edge where pc_wr=1, including for illegal instructions, and SHALL wrap 0xFFFFFFFF -> 0.
REQ-025 Changes on ins outside the IF->ID edge SHALL have no effect.

Reset
REQ-026 While reset=0, the block SHALL hold: state=IF, IR=0, instr_cnt=0, all strobes and selects 0.
REQ-027 Reset asserted mid-instruction SHALL deassert all strobes in the same cycle, with no partial write and no pc_wr.
REQ-028 After reset release, the first rising edge SHALL perform IF->ID with the current ins.

Structure
REQ-029 A shared package mips_pkg SHALL hold the opcode/funct constants, the state encoding and the alu_op codes.
REQ-030 Decoding SHALL be in one combinational sub-module, mips_decode: IR in; instruction class and selects out.
REQ-031 mips_ctrl SHALL contain only the FSM, IR, strobe logic and instr_cnt.

Verification
REQ-032 ins=0x00221821 (addu $3,$1,$2) -> states 0,1,2,4; cycle 4: reg_wr=1, pc_wr=1, reg_dst=1, alu_op=000; instr_cnt=1.
REQ-033 ins=0x8C040004 (lw) -> states 0,1,2,3,4; cycle 5: reg_wr=1, mem_to_reg=1, ext_op=1. Then ins=0xAC040008 (sw) -> cycle 4: mem_wr=1, pc_wr=1, reg_wr=0.
REQ-034 ins=0x10210002 (beq) -> cycle 3: pc_wr=1, npc_sel=1, alu_op=001. ins=0x08000003 (j) -> cycle 2: pc_wr=1, jctl=1.
REQ-035 ins=0xFC000000 -> cycle 2: illegal=1, pc_wr=1, no reg_wr/mem_wr; state returns to 0.
REQ-036 reset=0 while a lw is in MEM -> state=0 immediately, no strobes, instr_cnt=0.
REQ-037 instr_cnt forced to 0xFFFFFFFF, then one j completes -> instr_cnt=0.
